// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - seven-segment display controller with hex/decimal formatting
//
// Converts a WIDTH-bit value to NUM_DIGITS active-low seven-segment digits.
// Hex mode shows the value's nibbles directly. Decimal mode first runs a
// shift-add-3 (double-dabble) conversion, one bit per cycle. The value may be
// treated as signed, in which case a leading minus sign is shown. Leading
// zeros can be blanked. If the result cannot fit, every digit shows a dash.
//
// Ports:
//   Clk        - clock; all state updates on the rising edge
//   Reset_n    - asynchronous active-low reset
//   value      - number to display, sampled on load
//   mode       - 0 = hex, 1 = decimal, sampled on load
//   is_signed  - decimal only: value is two's complement, sampled on load
//   blank_en   - blank leading zero digits, sampled on load
//   load       - one-cycle conversion request, ignored while busy
//   busy       - conversion in progress
//   done       - one-cycle pulse on the edge that updates HEX_out
//   HEX_out    - {dp,g,f,e,d,c,b,a} per digit, active low, digit 0 in [7:0]
module seg_display_ctrl #(
  parameter int WIDTH      = 10,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [WIDTH-1:0]        value,
  input  logic                    mode,
  input  logic                    is_signed,
  input  logic                    blank_en,
  input  logic                    load,
  output logic                    busy,
  output logic                    done,
  output logic [8*NUM_DIGITS-1:0] HEX_out
);

  // Number of decimal digits in the largest unsigned WIDTH-bit value.
  function automatic int dec_digits(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 1;
    v = v / 10;
    while (v != 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  localparam int BCD_DIGITS = dec_digits(WIDTH);
  localparam int HEX_DIGITS = (WIDTH + 3) / 4;
  localparam int SRC_DIGITS = (BCD_DIGITS > HEX_DIGITS) ? BCD_DIGITS : HEX_DIGITS;
  // Digit register covers every source digit and every display position.
  localparam int DIG        = (SRC_DIGITS > NUM_DIGITS) ? SRC_DIGITS : NUM_DIGITS;
  localparam int CW         = $clog2(WIDTH + 1);

  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, CONVERT, FORMAT, UPDATE} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [CW-1:0]             cnt;
  logic [WIDTH-1:0]          sh;
  logic [4*DIG-1:0]          dig;
  logic                      neg;
  logic                      blank;
  logic [8*NUM_DIGITS-1:0]   seg_q;

  logic                      neg_in;
  logic [WIDTH-1:0]          mag;
  logic [4*DIG-1:0]          value_ext;
  logic [4*DIG-1:0]          dig_shift;
  logic [8*NUM_DIGITS-1:0]   seg_next;

  // The magnitude of any WIDTH-bit two's complement value fits in WIDTH
  // unsigned bits, so -2^(WIDTH-1) negates to exactly 2^(WIDTH-1).
  always_comb begin
    neg_in = mode & is_signed & value[WIDTH-1];
    mag    = neg_in ? -value : value;
  end

  always_comb begin
    value_ext              = '0;
    value_ext[WIDTH-1:0]   = value;
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift left by
  // one bit, feeding the next source bit into digit 0.
  always_comb begin
    logic [3:0] nib;
    logic       carry;
    nib       = '0;
    carry     = sh[WIDTH-1];
    dig_shift = '0;
    for (int i = 0; i < DIG; i++) begin
      nib = dig[i*4 +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      dig_shift[i*4 +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
  end

  // Segment formatting: find the most significant nonzero digit, decide
  // overflow (digits beyond the display, or no room for the minus sign),
  // then fill each position.
  always_comb begin
    int   msd;
    logic hi_nz;
    logic ovf;
    msd      = 0;
    hi_nz    = 1'b0;
    seg_next = '1;
    for (int i = 0; i < DIG; i++) begin
      if (dig[i*4 +: 4] != 4'd0) begin
        msd = i;
        if (i >= NUM_DIGITS) hi_nz = 1'b1;
      end
    end
    ovf = hi_nz || (neg && (msd + 1 >= NUM_DIGITS));
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ovf)
        seg_next[i*8 +: 8] = SEG_MINUS;
      else if (i <= msd)
        seg_next[i*8 +: 8] = seg7(dig[i*4 +: 4]);
      else if (neg && (i == msd + 1))
        seg_next[i*8 +: 8] = SEG_MINUS;
      else if (blank)
        seg_next[i*8 +: 8] = SEG_BLANK;
      else
        seg_next[i*8 +: 8] = seg7(4'h0);
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = mode ? CONVERT : FORMAT;
      CONVERT: if (cnt == CW'(WIDTH - 1)) state_next = FORMAT;
      FORMAT:  state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath. HEX_out changes only in UPDATE, so the conversion and
  // formatting intermediates are never visible.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt     <= '0;
      sh      <= '0;
      dig     <= '0;
      neg     <= 1'b0;
      blank   <= 1'b0;
      seg_q   <= '1;
      HEX_out <= '1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            cnt   <= '0;
            neg   <= neg_in;
            blank <= blank_en;
            if (mode) begin
              sh  <= mag;
              dig <= '0;
            end else begin
              sh  <= '0;
              dig <= value_ext;
            end
          end
        end
        CONVERT: begin
          dig <= dig_shift;
          sh  <= {sh[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        FORMAT: begin
          seg_q <= seg_next;
        end
        UPDATE: begin
          HEX_out <= seg_q;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - self-checking bench for seg_display_ctrl
module tb_seg_display_ctrl;

  localparam int W = 10;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [W-1:0] value = '0;
  logic         mode = 1'b0;
  logic         is_signed = 1'b0;
  logic         blank_en = 1'b0;
  logic         load = 1'b0;
  logic         busy6, done6, busy3, done3;
  logic [47:0]  hex6;
  logic [23:0]  hex3;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy;
  bit          m_done;
  int          m_left;
  logic [47:0] m_hex6, m_hex3, m_pend6, m_pend3;

  always #5 Clk = ~Clk;

  seg_display_ctrl #(.WIDTH(W), .NUM_DIGITS(6)) dut6 (
    .Clk(Clk), .Reset_n(Reset_n), .value(value), .mode(mode),
    .is_signed(is_signed), .blank_en(blank_en), .load(load),
    .busy(busy6), .done(done6), .HEX_out(hex6)
  );

  seg_display_ctrl #(.WIDTH(W), .NUM_DIGITS(3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .value(value), .mode(mode),
    .is_signed(is_signed), .blank_en(blank_en), .load(load),
    .busy(busy3), .done(done3), .HEX_out(hex3)
  );

  // Expected display from plain arithmetic on the value.
  function automatic logic [47:0] model_hex(int v, bit md, bit sg, bit bl, int nd);
    int          digs[8];
    bit          neg;
    bit          ovf;
    int          mag, msd, p;
    logic [47:0] r;
    neg = md && sg && (v >= 512);
    mag = neg ? (1024 - v) : v;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      digs[i] = md ? ((mag / p) % 10) : ((v >> (4 * i)) & 15);
      p = p * 10;
    end
    msd = 0;
    for (int i = 0; i < 8; i++) if (digs[i] != 0) msd = i;
    ovf = (msd >= nd) || (neg && (msd + 1 >= nd));
    r = '0;
    for (int i = 0; i < nd; i++) begin
      if (ovf)                       r[i*8 +: 8] = 8'hBF;
      else if (i <= msd)             r[i*8 +: 8] = SEG_TAB[digs[i]];
      else if (neg && i == msd + 1)  r[i*8 +: 8] = 8'hBF;
      else if (bl)                   r[i*8 +: 8] = 8'hFF;
      else                           r[i*8 +: 8] = 8'hC0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_done = 0;
    m_left = 0;
    m_hex6 = 48'hFFFF_FFFF_FFFF;
    m_hex3 = 48'h0000_00FF_FFFF;
  endtask

  // Advance the model by one rising edge using the inputs seen on that edge.
  task automatic model_edge();
    if (!Reset_n) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        m_hex6 = m_pend6;
        m_hex3 = m_pend3;
      end
    end else if (load) begin
      m_busy  = 1;
      m_left  = mode ? (W + 2) : 2;
      m_pend6 = model_hex(int'(value), mode, is_signed, blank_en, 6);
      m_pend3 = model_hex(int'(value), mode, is_signed, blank_en, 3);
    end
  endtask

  task automatic compare();
    check("busy6", busy6, m_busy);
    check("done6", done6, m_done);
    check("hex6",  hex6,  m_hex6);
    check("busy3", busy3, m_busy);
    check("done3", done3, m_done);
    check("hex3",  hex3,  m_hex3[23:0]);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    compare();
  endtask

  // Called at a falling edge: assert reset asynchronously, hold, release.
  task automatic do_reset();
    Reset_n = 1'b0;
    load    = 1'b0;
    #1;
    model_reset();
    compare();
    step();
    Reset_n = 1'b1;
  endtask

  task automatic run_load(input logic [W-1:0] v, input bit md, input bit sg, input bit bl,
                          input int n, output int dones);
    value = v; mode = md; is_signed = sg; blank_en = bl; load = 1'b1;
    step();
    load  = 1'b0;
    dones = 0;
    repeat (n) begin
      step();
      if (done6) dones++;
    end
  endtask

  initial begin
    int dones;

    model_reset();
    @(negedge Clk);
    compare();
    check("reset_hex6", hex6, 48'hFFFF_FFFF_FFFF);
    Reset_n = 1'b1;
    step();

    // Model pinned by hand-computed displays
    check("pin_1023",   model_hex(1023,  1, 0, 1, 6), 48'hFFFF_F9C0_A4B0);
    check("pin_m512",   model_hex(512,   1, 1, 1, 6), 48'hFFFF_BF92_F9A4);
    check("pin_2af",    model_hex(687,   0, 0, 0, 6), 48'hC0C0_C0A4_888E);
    check("pin_ovf3",   model_hex(1023,  1, 0, 1, 3), 48'h0000_00BF_BFBF);
    check("pin_m100_3", model_hex(924,   1, 1, 1, 3), 48'h0000_00BF_BFBF);
    check("pin_zero",   model_hex(0,     1, 0, 1, 6), 48'hFFFF_FFFF_FFC0);

    // Directed cases, back to back
    run_load(10'd1023, 1, 0, 1, W + 2, dones);
    check("d1023_hex6", hex6, 48'hFFFF_F9C0_A4B0);
    check("d1023_hex3", hex3, 24'hBFBFBF);
    check("d1023_dones", dones, 1);

    run_load(10'h200, 1, 1, 1, W + 2, dones);
    check("dm512_hex6", hex6, 48'hFFFF_BF92_F9A4);

    run_load(10'h2AF, 0, 0, 0, 2, dones);
    check("d2af_hex6", hex6, 48'hC0C0_C0A4_888E);
    check("d2af_hex3", hex3, 24'hA4888E);
    check("d2af_dones", dones, 1);

    run_load(10'h39C, 1, 1, 1, W + 2, dones);
    check("dm100_hex3", hex3, 24'hBFBFBF);
    check("dm100_hex6", hex6, 48'hFFFF_BFF9_C0C0);

    run_load(10'd0, 1, 0, 1, W + 2, dones);
    check("dzero_hex6", hex6, 48'hFFFF_FFFF_FFC0);

    // Load while busy is ignored
    value = 10'd123; mode = 1'b1; is_signed = 1'b0; blank_en = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    repeat (2) step();
    value = 10'd456; mode = 1'b0; blank_en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    repeat (W - 1) step();
    check("busyload_hex6", hex6, 48'hC0C0_C0F9_A4B0);

    // Reset during CONVERT
    value = 10'd999; mode = 1'b1; is_signed = 1'b0; blank_en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    repeat (4) step();
    do_reset();
    check("rst_busy6", busy6, 1'b0);
    check("rst_hex6", hex6, 48'hFFFF_FFFF_FFFF);
    dones = 0;
    repeat (W + 4) begin
      step();
      if (done6) dones++;
    end
    check("rst_no_done", dones, 0);
    check("rst_hex6_held", hex6, 48'hFFFF_FFFF_FFFF);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      load = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       value = 10'd0;
        1:       value = 10'h3FF;
        2:       value = 10'h200;
        3:       value = 10'($urandom_range(0, 15));
        default: value = 10'($urandom);
      endcase
      mode      = 1'($urandom_range(0, 1));
      is_signed = 1'($urandom_range(0, 1));
      blank_en  = 1'($urandom_range(0, 1));
      step();
    end
    load = 1'b0;
    repeat (W + 4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 10: bit width of the input value.
REQ-002 SHALL have parameter NUM_DIGITS, default 6: number of seven-segment digits driven.
REQ-003 SHALL have port Clk  input  1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port Reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port value  input  WIDTH: the number to display, sampled on load.
REQ-006 SHALL have port mode  input  1: display radix; 0 = hex, 1 = decimal. Sampled on load.
REQ-007 SHALL have port is_signed  input  1: in decimal mode, treat value as two's complement. Sampled on load.
REQ-008 SHALL have port blank_en  input  1: enable leading-zero blanking. Sampled on load.
REQ-009 SHALL have port load  input  1: request a conversion; one-cycle pulse.
REQ-010 SHALL have port busy  output  1: a conversion is in progress.
REQ-011 SHALL have port done  output  1: one-cycle pulse marking a display update.
REQ-012 SHALL have port HEX_out  output  8*NUM_DIGITS: active-low segments, {dp,g,f,e,d,c,b,a} per digit; digit 0 (rightmost) is bits [7:0].

Function
REQ-013 SHALL implement FSM states IDLE, CONVERT, FORMAT and UPDATE.
REQ-014 SHALL, in IDLE with load=1, capture value, mode, is_signed and blank_en, and assert busy from the next edge.
REQ-015 SHALL ignore load while busy=1; captured operands SHALL stay unchanged.
REQ-016 SHALL transition in hex mode IDLE->FORMAT->UPDATE->IDLE.
REQ-017 SHALL transition in decimal mode IDLE->CONVERT->FORMAT->UPDATE->IDLE.
REQ-018 SHALL, in decimal mode, run shift-add-3 (double-dabble) conversion in CONVERT, one bit per cycle, for exactly WIDTH cycles, using a cycle counter.
REQ-019 SHALL, in decimal mode with is_signed=1 and value MSB=1, convert the magnitude (two's complement negation, WIDTH+1 bits so that -2^(WIDTH-1) is exact) and set a negative flag.
REQ-020 SHALL use a BCD register wide enough for the largest magnitude. Any nonzero BCD digit at or above position NUM_DIGITS SHALL set overflow.
REQ-021 SHALL, in hex mode, zero-extend value to nibbles. A nonzero nibble at or above position NUM_DIGITS SHALL set overflow. Hex mode SHALL ignore is_signed.
REQ-022 SHALL have FORMAT map each digit to segments: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-023 SHALL, with blank_en=1, blank (FF) leading zero digits above the most significant nonzero digit; digit 0 SHALL never be blanked.
REQ-024 SHALL, when negative, place minus (BF) in the digit immediately left of the most significant shown digit (nonzero digit, or digit 0 if zero), regardless of blank_en.
REQ-025 SHALL set overflow if the minus sign has no free position; a negative value needs one more digit than its magnitude.
REQ-026 SHALL, on overflow, drive every digit to BF (all dashes).
REQ-027 SHALL hold dp=1 (off) on every digit in all cases.
REQ-028 SHALL, in UPDATE, register HEX_out, pulse done=1 for one cycle, and deassert busy on the same edge.
REQ-029 SHALL set latency from the edge that samples load to the edge updating HEX_out/done to 2 cycles in hex mode and WIDTH+2 cycles in decimal mode.
REQ-030 SHALL hold HEX_out constant between updates; no intermediate values SHALL be visible.
REQ-031 SHALL accept a load in the cycle after done (back-to-back operation).

Reset
REQ-032 SHALL, on Reset_n=0, immediately force state IDLE, busy=0, done=0, HEX_out all FF, and clear counter, BCD and flags.
REQ-033 SHALL, on reset mid-conversion, abort the conversion with no done pulse; HEX_out SHALL stay all FF until the next completed load.

Verification
REQ-034 SHALL cover: WIDTH=10, NUM_DIGITS=6, mode=1, is_signed=0, blank_en=1, value=1023 -> after 12 cycles, HEX_out digits[5:0] = FF FF F9 C0 A4 B0, with done pulsed once.
REQ-035 SHALL cover: mode=1, is_signed=1, blank_en=1, value=10'h200 (-512) -> digits[5:0] = FF FF BF 92 F9 A4.
REQ-036 SHALL cover: mode=0, blank_en=0, value=10'h2AF -> after 2 cycles, digits[5:0] = C0 C0 C0 A4 88 8E.
REQ-037 SHALL cover: NUM_DIGITS=3, mode=1, value=1023 -> all digits BF. With is_signed=1 and value=-100, all digits SHALL also be BF.
REQ-038 SHALL cover: value=0, blank_en=1, mode=1 -> digits[5:0] = FF FF FF FF FF C0.
REQ-039 SHALL cover: load during busy -> ignored, with the first result displayed. Reset_n low at cycle 5 of CONVERT -> busy=0, no done pulse, HEX_out all FF.
